// File: rtl/lsu_unit_if.sv
// Data-memory port of the load/store unit: valid/ready request channel plus a
// response channel that carries read data or the write acknowledge.
interface lsu_unit_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        mem_wstrb;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_rsp_valid;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_req_valid, mem_we, mem_addr, mem_wstrb, mem_wdata,
        input  mem_req_ready, mem_rsp_valid, mem_rdata
    );

    modport slave (
        input  mem_req_valid, mem_we, mem_addr, mem_wstrb, mem_wdata,
        output mem_req_ready, mem_rsp_valid, mem_rdata
    );
endinterface

// File: rtl/lsu_unit.sv
// Multi-cycle load/store unit: turns a core memory instruction into one
// data-memory transaction and returns lane-aligned, extended load data.
module lsu_unit #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic              i_load,
    input  logic              i_store,
    input  logic [7:0]        i_op_pmem,
    input  logic [1:0]        i_op_load_sext,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic              o_stall,
    output logic              o_done,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_err,
    lsu_unit_if.master        mem
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [1:0]        r_off;
    logic [3:0]        r_size;
    logic [1:0]        r_sext;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [3:0]        r_wstrb;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic              r_err;

    logic              w_req;
    logic              w_size_ok;
    logic              w_misalign;
    logic              w_illegal;
    logic              w_timeout;
    logic [DATA_W-1:0] w_shifted;
    logic [DATA_W-1:0] w_load_data;
    logic              w_unused_pmem;

    // Only the low nibble of the size mask carries meaning.
    assign w_unused_pmem = ^i_op_pmem[7:4];

    assign w_req      = i_start & (i_load | i_store);
    assign w_size_ok  = (i_op_pmem[3:0] == 4'h1) | (i_op_pmem[3:0] == 4'h3) |
                        (i_op_pmem[3:0] == 4'hF);
    assign w_misalign = ((i_op_pmem[3:0] == 4'h3) & i_addr[0]) |
                        ((i_op_pmem[3:0] == 4'hF) & (|i_addr[1:0]));
    assign w_illegal  = (i_load & i_store) | ~w_size_ok | w_misalign;
    // >= rather than ==: a handshake on the last REQ count lets WAIT start past it.
    assign w_timeout  = (r_cnt >= CNT_W'(TIMEOUT - 1));

    assign w_shifted = mem.mem_rdata >> {r_off, 3'b000};

    always_comb begin
        w_load_data = w_shifted;
        case (r_size)
            4'h1: w_load_data = {{(DATA_W-8){(r_sext == 2'b01) & w_shifted[7]}},
                                 w_shifted[7:0]};
            4'h3: w_load_data = {{(DATA_W-16){(r_sext == 2'b10) & w_shifted[15]}},
                                 w_shifted[15:0]};
            default: w_load_data = w_shifted;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_req) begin
                    w_state_next = w_illegal ? DONE : REQ;
                end
            end
            REQ: begin
                if (mem.mem_req_ready) begin
                    w_state_next = WAIT;
                end else if (w_timeout) begin
                    w_state_next = DONE;
                end
            end
            WAIT: begin
                if (mem.mem_rsp_valid || w_timeout) begin
                    w_state_next = DONE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_off   <= '0;
            r_size  <= '0;
            r_sext  <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wstrb <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                IDLE: begin
                    if (w_req && w_illegal) begin
                        r_err   <= 1'b1;
                        r_rdata <= '0;
                    end else if (w_req) begin
                        r_cnt   <= '0;
                        r_off   <= i_addr[1:0];
                        r_size  <= i_op_pmem[3:0];
                        r_sext  <= i_op_load_sext;
                        r_we    <= i_store;
                        r_addr  <= {i_addr[ADDR_W-1:2], 2'b00};
                        r_wstrb <= i_op_pmem[3:0] << i_addr[1:0];
                        r_wdata <= i_wdata << {i_addr[1:0], 3'b000};
                        r_err   <= 1'b0;
                    end
                end
                REQ: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (!mem.mem_req_ready && w_timeout) begin
                        r_err   <= 1'b1;
                        r_rdata <= '0;
                    end
                end
                WAIT: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (mem.mem_rsp_valid) begin
                        r_err   <= 1'b0;
                        r_rdata <= r_we ? '0 : w_load_data;
                    end else if (w_timeout) begin
                        r_err   <= 1'b1;
                        r_rdata <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_stall = (r_state == REQ) | (r_state == WAIT) | ((r_state == IDLE) & w_req);
    assign o_done  = (r_state == DONE);
    assign o_rdata = r_rdata;
    assign o_err   = r_err;

    assign mem.mem_req_valid = (r_state == REQ);
    assign mem.mem_we        = r_we;
    assign mem.mem_addr      = r_addr;
    assign mem.mem_wstrb     = r_wstrb;
    assign mem.mem_wdata     = r_wdata;
endmodule

// File: doc/lsu_unit.md
Name: lsu_unit

Overview:
- Multi-cycle load/store unit directly downstream of the control unit.
- Consumes the control unit's `load`, `store`, `op_PMEM` and `op_load_sext` outputs, the ALU result as address, and rs2 as store data.
- Runs a valid/ready request and response handshake to data memory and returns aligned, extended load data for register writeback.
- Stalls the core while an access is outstanding.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data bus width (fixed 4 byte lanes).
- TIMEOUT, 255, cycles allowed in REQ+WAIT before the access is aborted with an error.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  core presents a memory instruction this cycle; only sampled in IDLE.
- load  in  1  load instruction.
- store  in  1  store instruction.
- op_PMEM  in  8  size mask; only [3:0] are used: 8'h01 byte, 8'h03 half, 8'h0F word.
- op_load_sext  in  2  load extension: 00 zero-extend, 01 sign-extend byte, 10 sign-extend half, 11 treated as 00.
- addr  in  ADDR_W  effective address (ALU result).
- wdata  in  DATA_W  store data (rs2), in the low bytes.
- stall  out  1  core must hold PC and inputs.
- done  out  1  one-cycle pulse when the access completes.
- rdata  out  DATA_W  extended load result; valid when done is high.
- err  out  1  misaligned, illegal or timed-out access; valid when done is high.
- mem_req_valid  out  1  memory request valid.
- mem_req_ready  in  1  memory accepts the request.
- mem_we  out  1  1 = write.
- mem_addr  out  ADDR_W  word-aligned address: addr with [1:0] forced to 0.
- mem_wstrb  out  4  byte strobes.
- mem_wdata  out  DATA_W  lane-shifted store data.
- mem_rsp_valid  in  1  response valid; carries read data, or the write acknowledge.
- mem_rdata  in  DATA_W  raw read word.

Behaviour:
- Reset: state=IDLE. All outputs are 0: stall, done, rdata, err, mem_req_valid, mem_we, mem_addr, mem_wstrb, mem_wdata. The timeout counter is 0.
- Reset mid-operation: returns to IDLE on the next edge and drops mem_req_valid. Any late mem_rsp_valid arriving in IDLE is ignored.
- States: IDLE, REQ, WAIT, DONE.
- IDLE to REQ: when start & (load^store) and the access is aligned.
  - Latch addr[1:0], size, sext, we=store, wdata, and the strobes.
  - Strobes: mem_wstrb = op_PMEM[3:0] << addr[1:0].
  - Store data: mem_wdata = wdata << (8*addr[1:0]).
  - For a load, mem_wstrb holds the same read strobes; memory ignores them.
- IDLE to DONE with err=1, no memory request, rdata=0, when start and any of:
  - half access with addr[0]=1;
  - word access with addr[1:0]!=0;
  - load and store both 1;
  - op_PMEM[3:0] not in {1,3,F}.
- start with load=store=0: ignored, state stays IDLE, stall=0.
- REQ: mem_req_valid=1 with stable address, we, strobes and data. Moves to WAIT on the cycle mem_req_ready=1.
- WAIT: on mem_rsp_valid=1, captures mem_rdata and moves to DONE.
  - mem_rsp_valid is only honoured in WAIT; memory never responds in the handshake cycle.
- Timeout: the counter increments each cycle in REQ or WAIT and clears on entering REQ.
  - At count == TIMEOUT-1 without the expected handshake, the next state is DONE with err=1 and rdata=0.
  - mem_req_valid drops.
- DONE: done=1 and stall=0 for exactly one cycle, then IDLE.
  - A new start is sampled only in the following IDLE cycle, so back-to-back accesses have one idle cycle between them.
- Load data path:
  - Shift: shifted = mem_rdata >> (8*addr[1:0]).
  - Byte: rdata = {24{s & shifted[7]}, shifted[7:0]}, where s = (sext==01).
  - Half: rdata = {16{s & shifted[15]}, shifted[15:0]}, where s = (sext==10).
  - Word: rdata = shifted.
  - Stores return rdata=0.
- Stall: stall = (state==REQ) | (state==WAIT) | (state==IDLE & start & (load|store)). stall is low in DONE.
- Latency: with a zero-wait memory (ready=1, response one cycle after the handshake), done is asserted 3 cycles after the start cycle. Each wait cycle on ready or response adds one cycle.

Test Plan:
- lw addr=0x8000_0004, mem_rdata=0xDEAD_BEEF, zero wait -> mem_addr=0x8000_0004, wstrb=0xF, we=0; done at start+3, rdata=0xDEADBEEF, err=0.
- lb addr=0x8000_0003 (sext=01), rdata=0x80xx_xxxx -> rdata=0xFFFF_FF80. Same access as lbu (sext=00) -> rdata=0x0000_0080.
- sh addr=0x102, wdata=0x0000_ABCD -> mem_wstrb=4'b1100, mem_wdata=0xABCD_0000, mem_addr=0x100; write ack -> done, err=0.
- lw at 0x101 -> no mem_req_valid ever; done at start+1 with err=1, rdata=0. A store with load=store=1 gives the same result.
- ready held 0 for 5 cycles, then the response is delayed 3 cycles -> stall stays high throughout, mem_req_valid and all payload signals are stable, done occurs exactly once. With TIMEOUT=4 and ready stuck at 0 -> done with err=1 after 4 cycles in REQ.
- rst asserted while in WAIT, then a stale mem_rsp_valid arrives -> state=IDLE, done=0, stall=0, and the stale response is ignored.
